mux_n_reg: RTL and testbench
============================

MUX_N_REG -- requirements
Module: mux_n_reg

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of every input channel and of the output.
REQ-002 Parameter N, default 8, SHALL set the number of input channels; legal range 2..16.
REQ-003 Parameter MODE, default 0, SHALL select the grant policy: 0 = explicit select, 1 = round-robin.
REQ-004 Derived constant SELW = clog2(N) SHALL size every channel-index signal.
REQ-005 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-007 Port in_data, input, N*WIDTH, SHALL carry channel i in bits [i*WIDTH +: WIDTH].
REQ-008 Port in_valid, input, N, SHALL flag that channel i holds a word.
REQ-009 Port in_ready, output, N, SHALL flag that channel i's word is consumed this cycle.
REQ-010 Port sel, input, SELW, SHALL be the requested channel in MODE 0; it SHALL be ignored in MODE 1.
REQ-011 Port out_data, output, WIDTH, SHALL be the registered selected word.
REQ-012 Port out_valid, output, 1, SHALL flag that out_data holds a word.
REQ-013 Port out_ready, input, 1, SHALL flag that the consumer accepts out_data this cycle.
REQ-014 Port out_src, output, SELW, SHALL be the channel index that out_data came from.

Function
REQ-015 The internal signal load SHALL equal (!out_valid | out_ready).
REQ-016 In MODE 0 the candidate channel g SHALL be sel when sel < N, and 0 when sel >= N.
REQ-017 In MODE 1 the candidate channel g SHALL be the first i with in_valid[i] = 1, scanning ptr+1, ptr+2, ... ptr+N modulo N.
REQ-018 A grant SHALL occur when load = 1 and in_valid[g] = 1.
REQ-019 in_ready SHALL be combinational and one-hot at bit g during a grant, and all-zero otherwise.
REQ-020 On a grant, the next edge SHALL set out_data to in_data[g], out_src to g, and out_valid to 1; latency is 1 cycle.
REQ-021 When load = 1 and no grant occurs, the next edge SHALL clear out_valid to 0 and SHALL hold out_data and out_src.
REQ-022 When load = 0, out_data, out_valid and out_src SHALL hold.
REQ-023 Simultaneous out_ready = 1 and a grant SHALL replace the output word in the same edge, giving full throughput of 1 word/cycle with no bubble.
REQ-024 In MODE 1, ptr SHALL update to g on each grant and SHALL hold otherwise.
REQ-025 Wrap-around: when ptr = N-1, channel 0 SHALL have the highest priority.
REQ-026 In MODE 0, a sel change while load = 0 SHALL have no effect until load = 1.
REQ-027 No combinational path SHALL exist from in_data to out_data.
REQ-028 No combinational path SHALL exist from in_valid to out_valid.

Reset
REQ-029 While reset_n = 0: out_valid = 0, out_data = 0, out_src = 0, and ptr = N-1, all asynchronously.
REQ-030 While reset_n = 0, in_ready SHALL be all-zero.
REQ-031 Reset asserted mid-transfer SHALL discard the held word with no grant recorded; the first grant after release SHALL follow REQ-016/REQ-017 from the reset state.

Verification
REQ-032 Bench SHALL cover scenario 1: N=5, MODE 0, sel=2, in_valid=5'b00100, in_data[2]=32'hCAFE0002, out_ready=1 -> in_ready=5'b00100 that cycle; next cycle out_valid=1, out_data=32'hCAFE0002, out_src=2.
REQ-033 Bench SHALL cover scenario 2: MODE 0, sel=6 with N=5, in_valid[0]=1, in_data[0]=32'h11 -> grant channel 0, out_src=0, out_data=32'h11.
REQ-034 Bench SHALL cover scenario 3: out_valid=1 and out_ready=0 for 3 cycles with new in_valid -> in_ready=0, and out_data stable for all 3 cycles; out_ready=1 -> the new word is loaded next edge.
REQ-035 Bench SHALL cover scenario 4: N=4, MODE 1, in_valid=4'b1111, out_ready=1 held, after reset -> out_src sequence 0,1,2,3,0.
REQ-036 Bench SHALL cover scenario 5: MODE 1, ptr=3, in_valid=4'b1010 -> grant 1 then 3 then 1.
REQ-037 Bench SHALL cover scenario 6: reset_n pulled low mid-cycle while out_valid=1 -> out_valid=0 and out_data=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/mux_n_reg.sv
// mux_n_reg -- N-way registered multiplexer with valid/ready handshakes.
//
// Picks one of N input channels per cycle and registers its word onto a
// single valid/ready output stage. MODE 0 takes the channel named by sel
// (an out-of-range sel falls back to channel 0). MODE 1 grants round-robin,
// starting the search just after the last granted channel.
//
// Parameters
//   WIDTH : data width of each channel and of the output
//   N     : number of input channels (2..16)
//   MODE  : 0 = explicit select, 1 = round-robin
//   SELW  : width of every channel index, clog2(N)
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset_n   : asynchronous active-low reset
//   in_data   : N packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel word-present flags
//   in_ready  : per-channel consume strobe (one-hot on a grant, else zero)
//   sel       : requested channel (MODE 0 only)
//   out_data  : registered selected word
//   out_valid : out_data holds a word
//   out_ready : consumer accepts out_data this cycle
//   out_src   : channel index that out_data came from

module mux_n_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int MODE  = 0,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_src
);

    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic [SELW-1:0]  out_src_r;
    logic [SELW-1:0]  ptr_r;

    logic             load_s;
    logic             grant_s;
    logic [SELW-1:0]  g_s;
    logic [WIDTH-1:0] sel_data_s;

    // The output stage can take a new word when it is empty or being drained.
    assign load_s = ~out_valid_r | out_ready;

    // Candidate channel: explicit select with range fallback, or round-robin scan.
    always_comb begin
        int idx_v;
        g_s   = {SELW{1'b0}};
        idx_v = 0;
        if (MODE == 0) begin
            if (32'(sel) < 32'(N)) begin
                g_s = sel;
            end else begin
                g_s = {SELW{1'b0}};
            end
        end else begin
            // Scan from farthest to nearest so the nearest valid channel after
            // ptr is the last one written and therefore wins.
            for (int k = N; k >= 1; k--) begin
                idx_v = (int'(ptr_r) + k) % N;
                g_s   = in_valid[idx_v] ? SELW'(idx_v) : g_s;
            end
        end
    end

    // Grant is gated by reset so in_ready stays quiet while reset is held.
    assign grant_s = reset_n & load_s & in_valid[g_s];

    // Word of the candidate channel.
    assign sel_data_s = in_data[int'(g_s)*WIDTH +: WIDTH];

    // Consume strobe back to the granted channel.
    always_comb begin
        in_ready = {N{1'b0}};
        if (grant_s) begin
            in_ready[g_s] = 1'b1;
        end else begin
            in_ready = {N{1'b0}};
        end
    end

    // Output register stage: load on grant, drain to empty, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_src_r   <= {SELW{1'b0}};
        end else if (load_s) begin
            if (grant_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= sel_data_s;
                out_src_r   <= g_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Round-robin pointer: remembers the last granted channel. Reset to N-1 so
    // channel 0 has top priority after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= SELW'(N - 1);
        end else if ((MODE == 1) && grant_s) begin
            ptr_r <= g_s;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_src   = out_src_r;

endmodule

// File: tb/tb_mux_n_reg.sv
// Testbench for mux_n_reg: instance a (N=5, explicit select) and instance b
// (N=4, round-robin) share clock and reset. A behavioural model predicts
// in_ready and the output stage; it is compared every falling edge, and
// directed scenarios add hand-computed literal expectations.

module tb_mux_n_reg;

    logic clk;
    logic reset_n;

    // Instance a: N=5, MODE 0
    logic [5*32-1:0] a_in_data;
    logic [4:0]      a_in_valid;
    logic [4:0]      a_in_ready;
    logic [2:0]      a_sel;
    logic [31:0]     a_out_data;
    logic            a_out_valid;
    logic            a_out_ready;
    logic [2:0]      a_out_src;

    // Instance b: N=4, MODE 1
    logic [4*32-1:0] b_in_data;
    logic [3:0]      b_in_valid;
    logic [3:0]      b_in_ready;
    logic [1:0]      b_sel;
    logic [31:0]     b_out_data;
    logic            b_out_valid;
    logic            b_out_ready;
    logic [1:0]      b_out_src;

    int errors = 0;
    int checks = 0;

    mux_n_reg #(.WIDTH(32), .N(5), .MODE(0)) u_a (
        .clk(clk), .reset_n(reset_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sel(a_sel),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_src(a_out_src)
    );

    mux_n_reg #(.WIDTH(32), .N(4), .MODE(1)) u_b (
        .clk(clk), .reset_n(reset_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_src(b_out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Channel granted this cycle by the rules, or -1 when there is no grant.
    function automatic int grant_of(input int mode, input int n, input logic [15:0] valid,
                                    input int s, input int ptr, input bit ld, input bit rn);
        int c;
        c = -1;
        if (mode == 0) begin
            c = (s < n) ? s : 0;
        end else begin
            for (int k = 1; k <= n; k++) begin
                if (c < 0 && valid[(ptr + k) % n]) c = (ptr + k) % n;
            end
        end
        if (!rn || !ld || c < 0) return -1;
        if (!valid[c]) return -1;
        return c;
    endfunction

    // Model state
    bit          ma_v = 1'b0;
    logic [31:0] ma_d = 32'd0;
    int          ma_s = 0;
    bit          mb_v = 1'b0;
    logic [31:0] mb_d = 32'd0;
    int          mb_s = 0;
    int          mb_ptr = 3;

    int ga_s;
    int gb_s;

    always_comb ga_s = grant_of(0, 5, {11'd0, a_in_valid}, int'(a_sel), 0,
                                (!ma_v) || a_out_ready, reset_n);
    always_comb gb_s = grant_of(1, 4, {12'd0, b_in_valid}, int'(b_sel), mb_ptr,
                                (!mb_v) || b_out_ready, reset_n);

    // Model update on the same events as the design.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ma_v <= 1'b0; ma_d <= 32'd0; ma_s <= 0;
            mb_v <= 1'b0; mb_d <= 32'd0; mb_s <= 0; mb_ptr <= 3;
        end else begin
            if (ga_s >= 0) begin
                ma_v <= 1'b1; ma_d <= a_in_data[ga_s*32 +: 32]; ma_s <= ga_s;
            end else if (!ma_v || a_out_ready) begin
                ma_v <= 1'b0;
            end
            if (gb_s >= 0) begin
                mb_v <= 1'b1; mb_d <= b_in_data[gb_s*32 +: 32]; mb_s <= gb_s; mb_ptr <= gb_s;
            end else if (!mb_v || b_out_ready) begin
                mb_v <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("a_in_ready",  64'(a_in_ready),  (ga_s >= 0) ? (64'd1 << ga_s) : 64'd0);
        chk("a_out_valid", 64'(a_out_valid), 64'(ma_v));
        chk("a_out_data",  64'(a_out_data),  64'(ma_d));
        chk("a_out_src",   64'(a_out_src),   64'(ma_s));
        chk("b_in_ready",  64'(b_in_ready),  (gb_s >= 0) ? (64'd1 << gb_s) : 64'd0);
        chk("b_out_valid", 64'(b_out_valid), 64'(mb_v));
        chk("b_out_data",  64'(b_out_data),  64'(mb_d));
        chk("b_out_src",   64'(b_out_src),   64'(mb_s));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int rr_seq [5] = '{0, 1, 2, 3, 0};
    int rr_alt [3] = '{1, 3, 1};

    initial begin
        reset_n     = 1'b1;
        a_in_data   = '0; a_in_valid = 5'd0; a_sel = 3'd0; a_out_ready = 1'b0;
        b_in_data   = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        b_in_valid  = 4'd0; b_sel = 2'd0; b_out_ready = 1'b1;
        #1 reset_n  = 1'b0;
        @(negedge clk);
        chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_out_data",  64'(a_out_data),  64'd0);
        chk("rst_b_in_ready",  64'(b_in_ready),  64'd0);
        step();
        step();
        reset_n = 1'b1;

        // Scenario 1: sel=2, single valid channel
        step();
        a_sel = 3'd2; a_in_valid = 5'b00100; a_in_data[2*32 +: 32] = 32'hCAFE0002;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("s1_in_ready", 64'(a_in_ready), 64'h04);
        step();
        a_in_valid = 5'd0;
        @(negedge clk);
        chk("s1_out_valid", 64'(a_out_valid), 64'd1);
        chk("s1_out_data",  64'(a_out_data),  64'hCAFE0002);
        chk("s1_out_src",   64'(a_out_src),   64'd2);

        // Scenario 2: out-of-range sel falls back to channel 0
        step();
        a_sel = 3'd6; a_in_valid = 5'b00001; a_in_data[0 +: 32] = 32'h11;
        @(negedge clk);
        chk("s2_in_ready", 64'(a_in_ready), 64'h01);
        step();
        a_in_valid = 5'd0;
        @(negedge clk);
        chk("s2_out_src",  64'(a_out_src),  64'd0);
        chk("s2_out_data", 64'(a_out_data), 64'h11);

        // Scenario 3: backpressure for three cycles
        step();
        a_sel = 3'd1; a_in_valid = 5'b00010; a_in_data[1*32 +: 32] = 32'hA1;
        step();
        a_out_ready = 1'b0; a_in_data[1*32 +: 32] = 32'hB1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s3_stall_in_ready", 64'(a_in_ready), 64'd0);
            chk("s3_stall_out_data", 64'(a_out_data), 64'hA1);
            step();
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("s3_release_in_ready", 64'(a_in_ready), 64'h02);
        step();
        a_in_valid = 5'd0;
        @(negedge clk);
        chk("s3_new_out_data", 64'(a_out_data), 64'hB1);
        chk("s3_new_out_src",  64'(a_out_src),  64'd1);

        // Scenario 4: round-robin over all four channels from reset
        step();
        b_in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("s4_out_src",  64'(b_out_src),  64'(rr_seq[i]));
            chk("s4_out_data", 64'(b_out_data), 64'(32'hB0 + rr_seq[i]));
        end
        chk("s6_pre_out_valid", 64'(b_out_valid), 64'd1);

        // Scenario 6: asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6_out_valid", 64'(b_out_valid), 64'd0);
        chk("s6_out_data",  64'(b_out_data),  64'd0);
        chk("s6_out_src",   64'(b_out_src),   64'd0);
        chk("s6_in_ready",  64'(b_in_ready),  64'd0);

        // Scenario 5: ptr=3 after reset, channels 1 and 3 requesting
        b_in_valid = 4'b1010;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("s5_in_ready", 64'(b_in_ready), 64'h02);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("s5_out_src", 64'(b_out_src), 64'(rr_alt[i]));
        end

        b_in_valid = 4'd0;
        step();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
